top_level: RTL and testbench

TOP_LEVEL -- requirements
Module: top_level

---
 rtl/top_level.sv | 165 ++++++++++++++++
 tb/tb_top_level.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_level.sv
// Single-cycle accumulator processor: 8-bit datapath, 9-bit instructions, 10-bit PC.
// Branch targets come from a 16-entry lookup table indexed by the instruction's k field.

module data_mem #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] core [2**DATA_W];

  assign rdata = core[addr];

  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end
endmodule

module instr_rom (
  input  logic [9:0] addr,
  output logic [8:0] rdata
);
  logic [8:0] core [1024];

  assign rdata = core[addr];
endmodule

module reg_file #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] acc
);
  logic [DATA_W-1:0] core [16];

  assign rdata = core[raddr];
  assign acc   = core[0];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end
endmodule

module branch_lut (
  input  logic [3:0] addr,
  output logic [9:0] rdata
);
  logic [9:0] core [16];

  assign rdata = core[addr];
endmodule

module top_level #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  typedef enum logic [3:0] {
    OP_LD, OP_ST, OP_MOV, OP_MVA, OP_ADD, OP_SUB, OP_XOR, OP_AND,
    OP_SHR, OP_ADDI, OP_LI, OP_CLT, OP_BNZ, OP_BF, OP_JMP, OP_HALT
  } op_t;

  logic [9:0]        pc;
  logic [9:0]        pc_next;
  logic [9:0]        target;
  logic              sc_in;
  logic              sc_next;
  logic [8:0]        instr;
  op_t               op;
  logic [3:0]        r;
  logic [4:0]        imm;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] rr;
  logic [DATA_W-1:0] dm_rdata;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        rf_waddr;
  logic              rf_we;
  logic              dm_we;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [4:0] v);
    return $signed({{(DATA_W-5){v[4]}}, v});
  endfunction

  assign op   = op_t'(instr[8:5]);
  assign r    = instr[3:0];
  assign imm  = instr[4:0];
  assign done = (op == OP_HALT) && !reset;

  instr_rom ir1 (
    .addr  (pc),
    .rdata (instr)
  );

  branch_lut pl1 (
    .addr  (r),
    .rdata (target)
  );

  // Memory writes are suppressed while reset is held so preloaded contents survive.
  reg_file #(.DATA_W(DATA_W)) rf1 (
    .clk   (clk),
    .we    (rf_we && !reset),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (r),
    .rdata (rr),
    .acc   (acc)
  );

  data_mem #(.DATA_W(DATA_W)) dm1 (
    .clk   (clk),
    .we    (dm_we && !reset),
    .addr  (rr),
    .wdata (acc),
    .rdata (dm_rdata)
  );

  always_comb begin
    pc_next  = pc + 10'd1;
    sc_next  = sc_in;
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = acc;
    dm_we    = 1'b0;
    case (op)
      OP_LD:   begin rf_we = 1'b1; rf_wdata = dm_rdata; end
      OP_ST:   dm_we = 1'b1;
      OP_MOV:  begin rf_we = 1'b1; rf_waddr = r; end
      OP_MVA:  begin rf_we = 1'b1; rf_wdata = rr; end
      OP_ADD:  begin rf_we = 1'b1; rf_wdata = acc + rr; end
      OP_SUB:  begin rf_we = 1'b1; rf_wdata = acc - rr; end
      OP_XOR:  begin rf_we = 1'b1; rf_wdata = acc ^ rr; end
      OP_AND:  begin rf_we = 1'b1; rf_wdata = acc & rr; end
      OP_SHR:  begin rf_we = 1'b1; rf_wdata = rr >> 1; sc_next = rr[0]; end
      OP_ADDI: begin rf_we = 1'b1; rf_wdata = acc + $unsigned(sext_imm(imm)); end
      OP_LI:   begin rf_we = 1'b1; rf_wdata = DATA_W'(imm); end
      OP_CLT:  sc_next = (acc < rr);
      OP_BNZ:  if (acc != '0) pc_next = target;
      OP_BF:   if (sc_in) pc_next = target;
      OP_JMP:  pc_next = target;
      OP_HALT: pc_next = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= 10'd0;
      sc_in <= 1'b0;
    end else begin
      pc    <= pc_next;
      sc_in <= sc_next;
    end
  end
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: directed programs, random forward-branching programs checked
// against an instruction-level model, and a Hamming min/max program with a reset rerun.

module tb_top_level;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pp;

  logic [7:0] m_rf [16];
  logic [7:0] m_dm [256];
  logic [8:0] m_ir [1024];
  logic [9:0] m_pl [16];
  logic       m_sc;

  localparam int LD = 0, ST = 1, MOV = 2, MVA = 3, ADD = 4, SUB = 5, XOR = 6, AND = 7;
  localparam int SHR = 8, ADDI = 9, LI = 10, CLT = 11, BNZ = 12, BF = 13, JMP = 14, HALT = 15;

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ins(input int op, input int f);
    return {4'(op), 5'(f)};
  endfunction

  task automatic emit(input int op, input int f);
    m_ir[pp] = ins(op, f);
    pp++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) m_ir[i] = ins(HALT, 0);
    for (int i = 0; i < 256; i++) m_dm[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      m_rf[i] = 8'h00;
      m_pl[i] = 10'd0;
    end
    m_sc = 1'b0;
    pp = 0;
  endtask

  task automatic load_and_release();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) dut.ir1.core[i] = m_ir[i];
    for (int i = 0; i < 256; i++) dut.dm1.core[i] = m_dm[i];
    for (int i = 0; i < 16; i++) begin
      dut.rf1.core[i] = m_rf[i];
      dut.pl1.core[i] = m_pl[i];
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_until_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Instruction-set interpreter: applies each instruction's architectural effect in order.
  task automatic model_run(input int limit, output int steps);
    logic [9:0] pc;
    logic [8:0] w;
    logic [7:0] a, v, imm8;
    int r;
    pc = 10'd0;
    steps = 0;
    m_sc = 1'b0;
    while (m_ir[pc][8:5] != 4'hF && steps < limit) begin
      w = m_ir[pc];
      r = int'(w[3:0]);
      a = m_rf[0];
      v = m_rf[r];
      imm8 = {{3{w[4]}}, w[4:0]};
      pc = pc + 10'd1;
      case (int'(w[8:5]))
        LD:   m_rf[0] = m_dm[v];
        ST:   m_dm[v] = a;
        MOV:  m_rf[r] = a;
        MVA:  m_rf[0] = v;
        ADD:  m_rf[0] = a + v;
        SUB:  m_rf[0] = a - v;
        XOR:  m_rf[0] = a ^ v;
        AND:  m_rf[0] = a & v;
        SHR:  begin m_rf[0] = v >> 1; m_sc = v[0]; end
        ADDI: m_rf[0] = a + imm8;
        LI:   m_rf[0] = {3'b000, w[4:0]};
        CLT:  m_sc = (a < v);
        BNZ:  if (a != 8'h00) pc = m_pl[r];
        BF:   if (m_sc) pc = m_pl[r];
        JMP:  pc = m_pl[r];
        default: ;
      endcase
      steps++;
    end
  endtask

  task automatic test_prog_add();
    clear_model();
    emit(LI, 5); emit(MOV, 1); emit(LI, 3); emit(ADD, 1); emit(MOV, 2); emit(HALT, 0);
    load_and_release();
    step(4);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_early: got %b want 0", done); end
    step(1);
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done); end
    step(3);
    n_tests++;
    if (dut.pc !== 10'd5) begin n_fail++; $display("FAIL add_pc_hold: got %0d want 5", dut.pc); end
    n_tests++;
    if (dut.rf1.core[2] !== 8'd8) begin n_fail++; $display("FAIL add_r2: got %0d want 8", dut.rf1.core[2]); end
    n_tests++;
    if (dut.rf1.core[1] !== 8'd5) begin n_fail++; $display("FAIL add_r1: got %0d want 5", dut.rf1.core[1]); end
  endtask

  task automatic test_reset();
    dut.sc_in = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if (dut.pc !== 10'd0) begin n_fail++; $display("FAIL rst_pc: got %0d want 0", dut.pc); end
    n_tests++;
    if (dut.sc_in !== 1'b0) begin n_fail++; $display("FAIL rst_sc: got %b want 0", dut.sc_in); end
    clear_model();
    load_and_release();
    reset = 1'b1;
    #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done_halt: got %b want 0", done); end
    dut.rf1.core[0] = 8'h11;
    dut.rf1.core[3] = 8'h5A;
    dut.dm1.core[8'h5A] = 8'h77;
    dut.ir1.core[0] = ins(MOV, 3);
    dut.ir1.core[1] = ins(ST, 3);
    step(3);
    n_tests++;
    if (dut.rf1.core[3] !== 8'h5A) begin n_fail++; $display("FAIL rst_no_write: got %h want 5a", dut.rf1.core[3]); end
    @(negedge clk);
    reset = 1'b0;
    step(1);
    n_tests++;
    if (dut.rf1.core[3] !== 8'h11 || dut.pc !== 10'd1)
      begin n_fail++; $display("FAIL rst_first_instr: got r3=%h pc=%0d want r3=11 pc=1", dut.rf1.core[3], dut.pc); end
    step(1);
    n_tests++;
    if (dut.dm1.core[8'h11] !== 8'h11 || done !== 1'b1)
      begin n_fail++; $display("FAIL rst_resume: got dm=%h done=%b want dm=11 done=1", dut.dm1.core[8'h11], done); end
  endtask

  task automatic test_ld_st();
    int cyc;
    clear_model();
    m_rf[9] = 8'd63; m_rf[1] = 8'd64; m_dm[63] = 8'hA5;
    emit(LD, 9); emit(ST, 1);
    load_and_release();
    run_until_done(20, cyc);
    n_tests++;
    if (done !== 1'b1 || cyc != 2) begin n_fail++; $display("FAIL ldst_done: got done=%b cyc=%0d want 1/2", done, cyc); end
    n_tests++;
    if (dut.dm1.core[64] !== 8'hA5) begin n_fail++; $display("FAIL ldst_dm64: got %h want a5", dut.dm1.core[64]); end
  endtask

  task automatic test_branch_loop();
    int cyc;
    clear_model();
    m_pl[1] = 10'd4; m_pl[3] = 10'd1;
    emit(LI, 2); emit(ADDI, 31); emit(BNZ, 1); emit(HALT, 0); emit(JMP, 3);
    load_and_release();
    step(3);
    n_tests++;
    if (dut.pc !== 10'd4) begin n_fail++; $display("FAIL bnz_taken_pc: got %0d want 4", dut.pc); end
    run_until_done(50, cyc);
    n_tests++;
    if (done !== 1'b1 || cyc != 3) begin n_fail++; $display("FAIL bnz_exit: got done=%b cyc=%0d want 1/3", done, cyc); end
    n_tests++;
    if (dut.pc !== 10'd3 || dut.rf1.core[0] !== 8'd0)
      begin n_fail++; $display("FAIL bnz_final: got pc=%0d r0=%0d want 3/0", dut.pc, dut.rf1.core[0]); end
  endtask

  task automatic test_clt_bf();
    int cyc;
    for (int t = 0; t < 2; t++) begin
      clear_model();
      m_rf[14] = 8'd16; m_pl[2] = 10'd10;
      emit(LI, 15 + t); emit(CLT, 14); emit(BF, 2);
      load_and_release();
      run_until_done(20, cyc);
      n_tests++;
      if (dut.sc_in !== (t == 0)) begin n_fail++; $display("FAIL clt_sc%0d: got %b want %b", t, dut.sc_in, t == 0); end
      n_tests++;
      if (dut.pc !== ((t == 0) ? 10'd10 : 10'd3) || done !== 1'b1)
        begin n_fail++; $display("FAIL bf_pc%0d: got pc=%0d done=%b want %0d", t, dut.pc, done, (t == 0) ? 10 : 3); end
    end
  endtask

  task automatic test_pc_wrap();
    int cyc;
    clear_model();
    m_pl[5] = 10'd1023; m_pl[6] = 10'd5;
    emit(MVA, 15); emit(BNZ, 6); emit(LI, 1); emit(MOV, 15); emit(JMP, 5);
    m_ir[1023] = ins(LI, 9);
    load_and_release();
    step(5);
    n_tests++;
    if (dut.pc !== 10'd1023) begin n_fail++; $display("FAIL wrap_jmp: got %0d want 1023", dut.pc); end
    step(1);
    n_tests++;
    if (dut.pc !== 10'd0 || dut.rf1.core[0] !== 8'd9)
      begin n_fail++; $display("FAIL wrap_zero: got pc=%0d r0=%0d want 0/9", dut.pc, dut.rf1.core[0]); end
    run_until_done(20, cyc);
    n_tests++;
    if (done !== 1'b1 || dut.pc !== 10'd5 || dut.rf1.core[0] !== 8'd1 || cyc != 2)
      begin n_fail++; $display("FAIL wrap_final: got pc=%0d r0=%0d cyc=%0d want 5/1/2", dut.pc, dut.rf1.core[0], cyc); end
  endtask

  task automatic test_random(input int iter);
    int steps, cyc, bad, op, k;
    clear_model();
    for (int i = 0; i < 16; i++) begin
      m_rf[i] = 8'($urandom);
      m_pl[i] = 10'(4 * i + 4);
    end
    for (int i = 0; i < 256; i++) m_dm[i] = 8'($urandom);
    for (int a = 0; a < 64; a++) begin
      op = int'($urandom_range(0, 14));
      if (op >= BNZ) begin
        k = a / 4 + int'($urandom_range(0, 2));
        if (k > 15) k = 15;
        m_ir[a] = ins(op, k + 16 * int'($urandom_range(0, 1)));
      end else begin
        m_ir[a] = ins(op, int'($urandom_range(0, 31)));
      end
    end
    load_and_release();
    model_run(2000, steps);
    run_until_done(2000, cyc);
    n_tests++;
    if (done !== 1'b1 || cyc != steps)
      begin n_fail++; $display("FAIL rand%0d_cycles: got done=%b cyc=%0d want %0d", iter, done, cyc, steps); end
    n_tests++;
    if (dut.sc_in !== m_sc) begin n_fail++; $display("FAIL rand%0d_sc: got %b want %b", iter, dut.sc_in, m_sc); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (dut.rf1.core[i] !== m_rf[i])
        begin n_fail++; $display("FAIL rand%0d_r%0d: got %h want %h", iter, i, dut.rf1.core[i], m_rf[i]); end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut.dm1.core[i] !== m_dm[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rand%0d_dm: got %0d differing bytes want 0", iter, bad); end
  endtask

  // Popcount via a table u[h] = popcount(h) - 2h at dm[128+h], so popcount(x) = u[x>>1] + x.
  task automatic setup_hamming(output int mn, output int mx);
    logic [15:0] v [32];
    int d;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      v[i] = 16'($urandom);
      m_dm[2 * i] = v[i][15:8];
      m_dm[2 * i + 1] = v[i][7:0];
    end
    m_dm[64] = 8'd16;
    m_rf[7] = 8'd128; m_rf[8] = 8'd64; m_rf[9] = 8'd65; m_rf[10] = 8'd1;
    m_pl[0] = 10'd2; m_pl[1] = 10'd22; m_pl[2] = 10'd56; m_pl[3] = 10'd63;
    emit(LI, 1); emit(MOV, 12);
    emit(SHR, 12); emit(ADD, 7); emit(MOV, 3); emit(LD, 3); emit(SUB, 12); emit(MOV, 4);
    emit(MVA, 12); emit(ADD, 7); emit(MOV, 3); emit(MVA, 4); emit(ST, 3);
    emit(MVA, 12); emit(ADDI, 1); emit(MOV, 12); emit(XOR, 7); emit(BNZ, 0);
    emit(LI, 0); emit(MOV, 1); emit(LI, 2); emit(MOV, 2);
    emit(LD, 1); emit(MOV, 4); emit(LD, 2); emit(XOR, 4); emit(MOV, 6);
    emit(SHR, 6); emit(ADD, 7); emit(MOV, 3); emit(LD, 3); emit(ADD, 6); emit(MOV, 5);
    emit(MVA, 1); emit(ADD, 10); emit(MOV, 3); emit(LD, 3); emit(MOV, 4);
    emit(MVA, 2); emit(ADD, 10); emit(MOV, 3); emit(LD, 3); emit(XOR, 4); emit(MOV, 6);
    emit(SHR, 6); emit(ADD, 7); emit(MOV, 3); emit(LD, 3); emit(ADD, 6); emit(ADD, 5); emit(MOV, 5);
    emit(LD, 8); emit(CLT, 5); emit(BF, 2); emit(MVA, 5); emit(ST, 8);
    emit(LD, 9); emit(MOV, 13); emit(MVA, 5); emit(CLT, 13); emit(BF, 3); emit(MVA, 5); emit(ST, 9);
    emit(MVA, 2); emit(ADDI, 2); emit(MOV, 2); emit(XOR, 8); emit(BNZ, 1);
    emit(MVA, 1); emit(ADDI, 2); emit(MOV, 1); emit(ADDI, 2); emit(MOV, 2); emit(XOR, 8); emit(BNZ, 1);
    emit(HALT, 0);
    mn = 16;
    mx = 0;
    for (int i = 0; i < 32; i++)
      for (int j = i + 1; j < 32; j++) begin
        d = $countones(v[i] ^ v[j]);
        if (d < mn) mn = d;
        if (d > mx) mx = d;
      end
  endtask

  task automatic test_hamming();
    int mn, mx, cyc;
    setup_hamming(mn, mx);
    load_and_release();
    run_until_done(40000, cyc);
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ham_done: got %b want 1 after %0d cycles", done, cyc); end
    n_tests++;
    if (dut.dm1.core[64] !== 8'(mn)) begin n_fail++; $display("FAIL ham_min: got %0d want %0d", dut.dm1.core[64], mn); end
    n_tests++;
    if (dut.dm1.core[65] !== 8'(mx)) begin n_fail++; $display("FAIL ham_max: got %0d want %0d", dut.dm1.core[65], mx); end
  endtask

  task automatic test_reset_midrun();
    int mn, mx, cyc;
    setup_hamming(mn, mx);
    load_and_release();
    step(2500);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (dut.pc !== 10'd0 || done !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset: got pc=%0d done=%b want 0/0", dut.pc, done); end
    @(negedge clk);
    reset = 1'b0;
    run_until_done(40000, cyc);
    n_tests++;
    if (done !== 1'b1 || dut.dm1.core[64] !== 8'(mn) || dut.dm1.core[65] !== 8'(mx))
      begin n_fail++; $display("FAIL mid_rerun: got done=%b min=%0d max=%0d want 1/%0d/%0d",
                               done, dut.dm1.core[64], dut.dm1.core[65], mn, mx); end
  endtask

  initial begin
    test_prog_add();
    test_reset();
    test_ld_st();
    test_branch_loop();
    test_clt_bf();
    test_pc_wrap();
    for (int it = 0; it < 4; it++) test_random(it);
    test_hamming();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
